// File: rtl/cfg_reg_bank_ctrl_pkg.sv
// cfg_reg_pkg: shared register map, widths and commit FSM state for the SPI config bank.
package cfg_reg_pkg;
   localparam int ADDR_EN_OUT_LO = 0;
   localparam int ADDR_EN_OUT_HI = 1;
   localparam int ADDR_EN_PWM_LO = 2;
   localparam int ADDR_EN_PWM_HI = 3;
   localparam int ADDR_DUTY      = 4;
   localparam int NUM_CFG_REGS   = 5;
   localparam int ADDR_W         = 7;
   localparam int DATA_W         = 8;
   typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} commit_state_e;
endpackage

// File: rtl/cfg_reg_bank_ctrl_arb.sv
// rr_arb2: two-input round-robin arbiter; one-hot combinational grant, pointer advances on accept.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o
);
   // ptr_q=0 favours requester 0 when both request
   logic ptr_q, ptr_d;
   always_comb begin
      grant_o[0] = req_i[0] & (~req_i[1] | ~ptr_q);
      grant_o[1] = req_i[1] & (~req_i[0] | ptr_q);
      ptr_d      = grant_o[0] ? 1'b1 : grant_o[1] ? 1'b0 : ptr_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
endmodule

// File: rtl/cfg_reg_bank_ctrl.sv
// cfg_reg_bank_ctrl: five-register SPI config bank with two-port round-robin writes and
// shadowed PWM registers committed at PWM period boundaries.
module cfg_reg_bank_ctrl
   import cfg_reg_pkg::*;
#(
   parameter int MAX_ADDR  = 4,
   parameter bit SHADOW_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              period_start,
   output logic [DATA_W-1:0] en_reg_out_7_0,
   output logic [DATA_W-1:0] en_reg_out_15_8,
   output logic [DATA_W-1:0] en_reg_pwm_7_0,
   output logic [DATA_W-1:0] en_reg_pwm_15_8,
   output logic [DATA_W-1:0] pwm_duty_cycle,
   output logic              commit_pending,
   output logic              wr_err
);
   logic [1:0]        grant;
   logic              wr_en, addr_ok, shadow_wr;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] live_q [NUM_CFG_REGS];
   logic [DATA_W-1:0] live_d [NUM_CFG_REGS];
   logic [DATA_W-1:0] shadow_q [NUM_CFG_REGS];
   logic [DATA_W-1:0] shadow_d [NUM_CFG_REGS];
   logic              wr_err_q, wr_err_d;
   commit_state_e     state_q, state_d;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   ({req1_valid, req0_valid}),
      .grant_o (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Commit copies the pre-edge shadow, so a write landing on the same edge waits for the next period
   always_comb begin
      wr_en     = |grant;
      wr_addr   = grant[1] ? req1_addr : req0_addr;
      wr_data   = grant[1] ? req1_data : req0_data;
      addr_ok   = wr_addr <= ADDR_W'(MAX_ADDR);
      wr_err_d  = wr_en & ~addr_ok;
      live_d    = live_q;
      shadow_d  = shadow_q;
      state_d   = state_q;
      shadow_wr = 1'b0;
      if (state_q == ST_PENDING && period_start) begin
         for (int i = ADDR_EN_PWM_LO; i < NUM_CFG_REGS; i++) live_d[i] = shadow_q[i];
         state_d = ST_IDLE;
      end
      if (wr_en && addr_ok)
         for (int i = 0; i < NUM_CFG_REGS; i++)
            if (wr_addr == ADDR_W'(i)) begin
               if (SHADOW_EN && i >= ADDR_EN_PWM_LO) begin
                  shadow_d[i] = wr_data;
                  shadow_wr   = 1'b1;
               end else begin
                  live_d[i] = wr_data;
               end
            end
      if (shadow_wr) state_d = ST_PENDING;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NUM_CFG_REGS; i++) begin
            live_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
         state_q  <= ST_IDLE;
         wr_err_q <= 1'b0;
      end else begin
         live_q   <= live_d;
         shadow_q <= shadow_d;
         state_q  <= state_d;
         wr_err_q <= wr_err_d;
      end

   assign en_reg_out_7_0  = live_q[ADDR_EN_OUT_LO];
   assign en_reg_out_15_8 = live_q[ADDR_EN_OUT_HI];
   assign en_reg_pwm_7_0  = live_q[ADDR_EN_PWM_LO];
   assign en_reg_pwm_15_8 = live_q[ADDR_EN_PWM_HI];
   assign pwm_duty_cycle  = live_q[ADDR_DUTY];
   assign commit_pending  = state_q == ST_PENDING;
   assign wr_err          = wr_err_q;
endmodule

// File: tb/tb_cfg_reg_bank_ctrl.sv
// tb_cfg_reg_bank_ctrl: directed vector table, reset corner case and random traffic
// checked against a register-map reference model.
module tb_cfg_reg_bank_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid, period_start;
   logic [6:0] req0_addr, req1_addr;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready, commit_pending, wr_err;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] m_live [5];
   logic [7:0] m_shadow [5];
   bit         m_pend, m_err, m_last;

   typedef struct packed {
      logic       v0;
      logic [6:0] a0;
      logic [7:0] d0;
      logic       v1;
      logic [6:0] a1;
      logic [7:0] d1;
      logic       ps;
      logic       r0, r1;
      logic [4:0][7:0] o;
      logic       pend, err;
   } vec_t;

   vec_t tbl [13];

   cfg_reg_bank_ctrl #(.MAX_ADDR(4), .SHADOW_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .period_start(period_start),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .commit_pending(commit_pending), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic v0, logic [6:0] a0, logic [7:0] d0, logic v1, logic [6:0] a1,
                               logic [7:0] d1, logic ps, logic r0, logic r1, logic [7:0] o0,
                               logic [7:0] o1, logic [7:0] o2, logic [7:0] o3, logic [7:0] o4,
                               logic pend, logic err);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.ps = ps;
      v.r0 = r0; v.r1 = r1; v.o = {o4, o3, o2, o1, o0}; v.pend = pend; v.err = err;
      return v;
   endfunction

   function automatic logic [39:0] dut_regs();
      return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
   endfunction

   function automatic logic [39:0] mdl_regs();
      return {m_live[4], m_live[3], m_live[2], m_live[1], m_live[0]};
   endfunction

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 5; i++) begin
         m_live[i] = 8'h00;
         m_shadow[i] = 8'h00;
      end
      m_pend = 0; m_err = 0; m_last = 1;
   endtask

   task automatic drive(input vec_t v);
      req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
      req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
      period_start = v.ps;
   endtask

   // Called a little after inputs change; checks grants, clocks one edge, checks registered outputs.
   task automatic cyc();
      bit g0, g1, acc;
      int a;
      logic [7:0] d;
      g0 = req0_valid && (!req1_valid || m_last);
      g1 = req1_valid && (!req0_valid || !m_last);
      chk("mdl_ready0", {39'd0, req0_ready}, {39'd0, g0});
      chk("mdl_ready1", {39'd0, req1_ready}, {39'd0, g1});
      acc = g0 || g1;
      a = g1 ? int'(req1_addr) : int'(req0_addr);
      d = g1 ? req1_data : req0_data;
      @(posedge clk);
      if (m_pend && period_start) begin
         for (int i = 2; i < 5; i++) m_live[i] = m_shadow[i];
         m_pend = 0;
      end
      m_err = acc && a > 4;
      if (acc && a <= 4) begin
         if (a >= 2) begin
            m_shadow[a] = d;
            m_pend = 1;
         end else m_live[a] = d;
      end
      if (acc) m_last = g1;
      #1;
      chk("mdl_regs", dut_regs(), mdl_regs());
      chk("mdl_pending", {39'd0, commit_pending}, {39'd0, m_pend});
      chk("mdl_wr_err", {39'd0, wr_err}, {39'd0, m_err});
   endtask

   initial begin
      bit hold0, hold1;
      tbl[0]  = mk(1, 0, 8'hA5, 0, 0, 8'h00, 0, 1, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
      tbl[1]  = mk(0, 0, 8'h00, 1, 1, 8'h33, 0, 0, 1, 8'hA5, 8'h33, 8'h00, 8'h00, 8'h00, 0, 0);
      tbl[2]  = mk(1, 1, 8'h10, 1, 1, 8'h21, 0, 1, 0, 8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0);
      tbl[3]  = mk(1, 1, 8'h12, 1, 1, 8'h21, 0, 0, 1, 8'hA5, 8'h21, 8'h00, 8'h00, 8'h00, 0, 0);
      tbl[4]  = mk(1, 1, 8'h12, 1, 1, 8'h23, 0, 1, 0, 8'hA5, 8'h12, 8'h00, 8'h00, 8'h00, 0, 0);
      tbl[5]  = mk(1, 1, 8'h14, 1, 1, 8'h23, 0, 0, 1, 8'hA5, 8'h23, 8'h00, 8'h00, 8'h00, 0, 0);
      tbl[6]  = mk(1, 4, 8'h80, 0, 0, 8'h00, 0, 1, 0, 8'hA5, 8'h23, 8'h00, 8'h00, 8'h00, 1, 0);
      tbl[7]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'hA5, 8'h23, 8'h00, 8'h00, 8'h80, 0, 0);
      tbl[8]  = mk(1, 2, 8'h55, 0, 0, 8'h00, 0, 1, 0, 8'hA5, 8'h23, 8'h00, 8'h00, 8'h80, 1, 0);
      tbl[9]  = mk(1, 3, 8'h0F, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 8'h23, 8'h55, 8'h00, 8'h80, 1, 0);
      tbl[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'hA5, 8'h23, 8'h55, 8'h0F, 8'h80, 0, 0);
      tbl[11] = mk(0, 0, 8'h00, 1, 5, 8'hFF, 0, 0, 1, 8'hA5, 8'h23, 8'h55, 8'h0F, 8'h80, 0, 1);
      tbl[12] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'hA5, 8'h23, 8'h55, 8'h0F, 8'h80, 0, 0);
      rst_n = 1'b0;
      drive('0);
      mdl_reset();
      repeat (2) @(negedge clk);
      chk("rst_regs", dut_regs(), 40'd0);
      chk("rst_pending", {39'd0, commit_pending}, 40'd0);
      chk("rst_wr_err", {39'd0, wr_err}, 40'd0);
      rst_n = 1'b1;
      @(negedge clk);
      foreach (tbl[k]) begin
         drive(tbl[k]);
         #1;
         chk($sformatf("tbl%0d_ready0", k), {39'd0, req0_ready}, {39'd0, tbl[k].r0});
         chk($sformatf("tbl%0d_ready1", k), {39'd0, req1_ready}, {39'd0, tbl[k].r1});
         cyc();
         chk($sformatf("tbl%0d_regs", k), dut_regs(), tbl[k].o);
         chk($sformatf("tbl%0d_pending", k), {39'd0, commit_pending}, {39'd0, tbl[k].pend});
         chk($sformatf("tbl%0d_wr_err", k), {39'd0, wr_err}, {39'd0, tbl[k].err});
         @(negedge clk);
      end
      // Reset while a duty update is still only in the shadow
      drive(mk(1, 4, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      cyc();
      chk("pre_rst_pending", {39'd0, commit_pending}, 40'd1);
      @(negedge clk);
      drive('0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_regs", dut_regs(), 40'd0);
      chk("async_rst_pending", {39'd0, commit_pending}, 40'd0);
      mdl_reset();
      @(negedge clk);
      rst_n = 1'b1;
      period_start = 1'b1;
      #1;
      cyc();
      chk("post_rst_duty", {32'd0, pwm_duty_cycle}, 40'd0);
      @(negedge clk);
      drive(mk(1, 0, 8'h01, 1, 0, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk("post_rst_favour0", {38'd0, req1_ready, req0_ready}, 40'd1);
      cyc();
      @(negedge clk);
      hold0 = 0; hold1 = 0;
      for (int n = 0; n < 400; n++) begin
         if (!hold0 || $urandom_range(0, 7) == 0) begin
            req0_valid = $urandom_range(0, 2) != 0;
            req0_addr = 7'($urandom_range(0, 6));
            req0_data = 8'($urandom);
         end
         if (!hold1 || $urandom_range(0, 7) == 0) begin
            req1_valid = $urandom_range(0, 2) != 0;
            req1_addr = 7'($urandom_range(0, 6));
            req1_data = 8'($urandom);
         end
         period_start = $urandom_range(0, 3) == 0;
         #1;
         hold0 = req0_valid && !req0_ready;
         hold1 = req1_valid && !req1_ready;
         cyc();
         @(negedge clk);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cfg_reg_bank_ctrl.md
Name: cfg_reg_bank_ctrl

Overview:
- Owns the five 8-bit configuration registers of the SPI config space.
- Arbitrates writes from two requesters: port 0 is the SPI peripheral write port; port 1 is the on-chip debug/boot-load port.
- Writes to PWM registers are staged in shadow copies and committed only at a PWM period boundary, so the PWM never sees a torn configuration mid-period.

Parameters:
- MAX_ADDR, 4, highest valid register address; addresses above it are rejected.
- SHADOW_EN, 1, 1 = addr 2..4 go through shadow/commit; 0 = every write updates live registers directly.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 (SPI) write request
- req0_addr  in  7  requester 0 register address
- req0_data  in  8  requester 0 write data
- req0_ready  out  1  requester 0 grant; handshake completes when valid && ready
- req1_valid  in  1  requester 1 (debug) write request
- req1_addr  in  7  requester 1 register address
- req1_data  in  8  requester 1 write data
- req1_ready  out  1  requester 1 grant
- period_start  in  1  one-cycle pulse from the PWM counter at each period wrap
- en_reg_out_7_0  out  8  live reg 0
- en_reg_out_15_8  out  8  live reg 1
- en_reg_pwm_7_0  out  8  live reg 2
- en_reg_pwm_15_8  out  8  live reg 3
- pwm_duty_cycle  out  8  live reg 4
- commit_pending  out  1  shadow holds uncommitted PWM data
- wr_err  out  1  one-cycle pulse: an accepted write had addr > MAX_ADDR

Behaviour:
- Reset (asynchronous):
  - All live and shadow registers go to 0x00.
  - commit_pending=0, wr_err=0.
  - Round-robin pointer favours req0.
- Arbitration:
  - At most one write is accepted per cycle.
  - readyN is combinational from the valid inputs and the pointer. It is never asserted unless reqN_valid is asserted, and at most one ready is high per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - The pointer updates only on an accepted write.
  - A requester must hold valid/addr/data stable until ready. Dropping valid before ready is legal and discards the request.
- Write decode, for a write accepted at edge N:
  - addr 0 or 1: live register updated at edge N.
  - addr 2..4 with SHADOW_EN=1: shadow register updated at edge N; commit_pending=1 from edge N.
  - addr 2..4 with SHADOW_EN=0: live register updated at edge N.
  - addr > MAX_ADDR: handshake still completes, no register changes, wr_err high for exactly the cycle after edge N.
- Commit FSM, states IDLE and PENDING:
  - IDLE -> PENDING on an accepted shadowed write.
  - PENDING -> IDLE when period_start=1 at an edge. Live regs 2..4 take the shadow values as they stood before that edge.
  - A shadowed write accepted at the same edge as period_start is not included in that commit. It goes to shadow and the FSM stays in PENDING, or re-enters it.
  - period_start in IDLE has no effect.
  - Multiple writes to the same shadow address before a commit: the last one wins.
- Shadow contents persist after a commit; the shadow always mirrors the last written values.
- Reset mid-PENDING discards uncommitted shadow data.
- Outputs are registered. The only combinational paths are the ready signals.

Decomposition:
- Package cfg_reg_pkg holds:
  - localparams ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_DUTY=4, NUM_CFG_REGS=5
  - ADDR_W=7, DATA_W=8
  - the commit FSM state enum
- One sub-module, rr_arb2: two-input round-robin arbiter with a one-hot grant and a pointer that updates on accept.

Test Plan:
- Reset, then req0 writes addr 0 = 0xA5 -> req0_ready=1 same cycle; en_reg_out_7_0=0xA5 one edge later; no wr_err.
- Both valid for 4 cycles, req0 to addr 1 and req1 to addr 1 with distinct data -> grants alternate 0,1,0,1; final en_reg_out_15_8 equals req1's second data.
- req0 writes addr 4 = 0x80, no period_start -> pwm_duty_cycle stays 0x00 and commit_pending=1; pulse period_start -> pwm_duty_cycle=0x80 and commit_pending=0 at that edge.
- Write addr 3 = 0x0F accepted on the same edge as period_start -> en_reg_pwm_15_8 unchanged and commit_pending=1; next period_start -> 0x0F.
- req1 writes addr 0x05 = 0xFF -> handshake completes, all outputs unchanged, wr_err high for exactly one cycle.
- Assert rst_n low while commit_pending=1 with shadow duty 0x40 -> all outputs 0 immediately; after release, period_start leaves pwm_duty_cycle=0x00.
